crossbar_sequencer: RTL and testbench

//  Control-only sequencer in front of the output crossbar. Accepts one tile of products and

---
 rtl/crossbar_seq_pkg.sv | 21 ++
 rtl/sat_counter.sv | 28 ++
 rtl/crossbar_sequencer.sv | 164 ++++++++++++++++
 tb/tb_crossbar_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_seq_pkg.sv
// Shared types for the crossbar sequencer.
// Bitwidth codes, FSM states and error-flag bit positions.
package crossbar_seq_pkg;

   typedef enum logic [1:0] {
      BW2 = 2'b00,
      BW4 = 2'b01,
      BW8 = 2'b10
   } bw_e;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      WAIT,
      DRAIN
   } seq_state_e;

   localparam int ERR_TIMEOUT_BIT = 0;
   localparam int ERR_CFG_BIT     = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter.
// Clear has priority over increment; holds at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clear,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   // count register: clear wins, then saturating increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/crossbar_sequencer.sv
// Control sequencer in front of the output crossbar.
// Holds operands through bank-conflict stalls and signals layer completion.
module crossbar_sequencer
   import crossbar_seq_pkg::*;
#(
   parameter int STALL_TIMEOUT = 1024,
   parameter int DRAIN_CYCLES  = 2,
   parameter int CNT_WIDTH     = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cfg_valid,
   input  logic [1:0]           cfg_bitwidth,
   output logic                 cfg_ready,
   input  logic                 tile_valid,
   input  logic                 tile_last,
   output logic                 tile_ready,
   output logic                 operand_hold,
   output logic [1:0]           xbar_bitwidth,
   input  logic                 xbar_stall,
   output logic                 busy,
   output logic                 layer_done,
   output logic [1:0]           err_flags,
   input  logic                 err_clear,
   input  logic                 stat_clear,
   output logic [CNT_WIDTH-1:0] stat_tiles,
   output logic [CNT_WIDTH-1:0] stat_stall_cycles
);

   localparam int SW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   seq_state_e r_state;
   seq_state_e w_state_nxt;
   bw_e        r_bw;
   logic       r_last;
   logic [SW-1:0] r_stall_cnt;
   logic [DW-1:0] r_drain_cnt;
   logic [1:0] r_err;
   logic [1:0] w_err_set;
   logic       w_cfg_take;
   logic       w_accept;
   logic       w_done;
   logic       w_timeout;
   logic       w_stall_inc;

   // next-state decode and per-cycle event strobes
   always_comb begin
      w_state_nxt = r_state;
      w_cfg_take  = 1'b0;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      w_timeout   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (cfg_valid) begin
               w_cfg_take = 1'b1;
            end else if (tile_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ARM;
            end
         end
         ARM: begin
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (!xbar_stall) begin
               w_done = 1'b1;
            end else if (r_stall_cnt == SW'(STALL_TIMEOUT - 1)) begin
               w_done    = 1'b1;
               w_timeout = 1'b1;
            end
            if (w_done) begin
               w_state_nxt = r_last ? DRAIN : IDLE;
            end
         end
         DRAIN: begin
            if (r_drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // new error sources this cycle
   always_comb begin
      w_err_set = '0;
      w_err_set[ERR_TIMEOUT_BIT] = w_timeout;
      w_err_set[ERR_CFG_BIT]     = w_cfg_take && (cfg_bitwidth == 2'b11);
   end

   assign w_stall_inc = (r_state == WAIT) && xbar_stall;

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // bitwidth only moves on an IDLE cfg handshake with a legal code
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bw <= BW8;
      end else if (w_cfg_take && (cfg_bitwidth != 2'b11)) begin
         r_bw <= bw_e'(cfg_bitwidth);
      end
   end

   // tile_last is captured at acceptance; upstream may drop it later
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      r_last <= 1'b0;
      else if (w_accept) r_last <= tile_last;
   end

   // consecutive stall cycles of the current tile
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                      r_stall_cnt <= '0;
      else if (w_stall_inc && !w_done)   r_stall_cnt <= r_stall_cnt + SW'(1);
      else                               r_stall_cnt <= '0;
   end

   // drain cycle counter, restarts on every DRAIN entry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_drain_cnt <= '0;
      end else if ((r_state == DRAIN) && (w_state_nxt == DRAIN)) begin
         r_drain_cnt <= r_drain_cnt + DW'(1);
      end else begin
         r_drain_cnt <= '0;
      end
   end

   // sticky error flags; a new error beats a same-cycle clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_err <= '0;
      else          r_err <= (r_err & ~{2{err_clear}}) | w_err_set;
   end

   sat_counter #(.W(CNT_WIDTH)) u_tiles (
      .clk     (clk),
      .rst_n   (reset_n),
      .i_clear (stat_clear),
      .i_inc   (w_done),
      .o_count (stat_tiles)
   );

   sat_counter #(.W(CNT_WIDTH)) u_stalls (
      .clk     (clk),
      .rst_n   (reset_n),
      .i_clear (stat_clear),
      .i_inc   (w_stall_inc),
      .o_count (stat_stall_cycles)
   );

   assign cfg_ready     = (r_state == IDLE);
   assign busy          = (r_state != IDLE);
   assign operand_hold  = (r_state == ARM) || (r_state == WAIT);
   assign tile_ready    = w_done;
   assign layer_done    = (r_state == DRAIN) && (w_state_nxt == IDLE);
   assign xbar_bitwidth = r_bw;
   assign err_flags     = r_err;

endmodule

// File: tb/tb_crossbar_sequencer.sv
// Bench for crossbar_sequencer.
// Scoreboard holds expected operand-hold length and drain per tile.
module tb_crossbar_sequencer;

   localparam int TO    = 8;
   localparam int DRAIN = 2;
   localparam int CW    = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cfg_valid;
   logic [1:0]    cfg_bitwidth;
   logic          cfg_ready;
   logic          tile_valid;
   logic          tile_last;
   logic          tile_ready;
   logic          operand_hold;
   logic [1:0]    xbar_bitwidth;
   logic          xbar_stall;
   logic          busy;
   logic          layer_done;
   logic [1:0]    err_flags;
   logic          err_clear;
   logic          stat_clear;
   logic [CW-1:0] stat_tiles;
   logic [CW-1:0] stat_stall_cycles;

   typedef struct {
      int hold;
      bit last;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   n_chk    = 0;
   int   n_fail   = 0;
   int   m_tiles  = 0;
   int   m_stalls = 0;
   int   hold_run = 0;
   int   ld_cd    = 0;

   crossbar_sequencer #(
      .STALL_TIMEOUT (TO),
      .DRAIN_CYCLES  (DRAIN),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .cfg_valid         (cfg_valid),
      .cfg_bitwidth      (cfg_bitwidth),
      .cfg_ready         (cfg_ready),
      .tile_valid        (tile_valid),
      .tile_last         (tile_last),
      .tile_ready        (tile_ready),
      .operand_hold      (operand_hold),
      .xbar_bitwidth     (xbar_bitwidth),
      .xbar_stall        (xbar_stall),
      .busy              (busy),
      .layer_done        (layer_done),
      .err_flags         (err_flags),
      .err_clear         (err_clear),
      .stat_clear        (stat_clear),
      .stat_tiles        (stat_tiles),
      .stat_stall_cycles (stat_stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_bw"},     32'(xbar_bitwidth), 2);
      chk({tag, "_cfgrdy"}, 32'(cfg_ready), 1);
      chk({tag, "_trdy"},   32'(tile_ready), 0);
      chk({tag, "_hold"},   32'(operand_hold), 0);
      chk({tag, "_ldone"},  32'(layer_done), 0);
      chk({tag, "_busy"},   32'(busy), 0);
      chk({tag, "_err"},    32'(err_flags), 0);
      chk({tag, "_tiles"},  stat_tiles, 0);
      chk({tag, "_stalls"}, stat_stall_cycles, 0);
   endtask

   // tile_ready/layer_done monitor against the scoreboard
   always begin
      @(negedge clk);
      if (operand_hold) hold_run++;
      else              hold_run = 0;
      if (layer_done || (ld_cd == 1))
         chk("layer_done", 32'(layer_done), (ld_cd == 1) ? 1 : 0);
      if (ld_cd > 0) ld_cd--;
      if (tile_ready) begin
         if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 1);
         end else begin
            m_e = sb.pop_front();
            chk("hold_len", hold_run, m_e.hold);
            if (m_e.last) ld_cd = DRAIN;
         end
      end
   end

   // one tile with n stall cycles in WAIT (n >= TO means stuck)
   task automatic run_tile(input bit last, input int n);
      exp_t e;
      bit   done;
      e.hold = (n >= TO) ? TO + 1 : n + 2;
      e.last = last;
      sb.push_back(e);
      tile_valid = 1'b1;
      tile_last  = last;
      xbar_stall = 1'b0;
      tick();
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         xbar_stall = (c == 0) ? (n > 0) : (c <= n);
         @(negedge clk);
         done = tile_ready;
         tick();
      end
      tile_valid = 1'b0;
      tile_last  = 1'b0;
      xbar_stall = 1'b0;
      chk("tile_ready_seen", 32'(done), 1);
      m_tiles++;
      m_stalls += (n >= TO) ? TO : n;
      @(negedge clk);
      chk("stat_tiles", stat_tiles, m_tiles);
      chk("stat_stalls", stat_stall_cycles, m_stalls);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n      = 1'b0;
      cfg_valid    = 1'b0;
      cfg_bitwidth = 2'b00;
      tile_valid   = 1'b0;
      tile_last    = 1'b0;
      xbar_stall   = 1'b0;
      err_clear    = 1'b0;
      stat_clear   = 1'b0;
      tick();
      @(negedge clk);
      chk_reset("rst");
      tick();
      reset_n = 1'b1;

      // bitwidth config, illegal code, error clear priority
      cfg_valid = 1'b1;
      cfg_bitwidth = 2'b00;
      @(negedge clk);
      chk("cfg_ready_idle", 32'(cfg_ready), 1);
      chk("bw_before", 32'(xbar_bitwidth), 2);
      tick();
      cfg_valid = 1'b0;
      @(negedge clk);
      chk("bw_2b", 32'(xbar_bitwidth), 0);
      tick();
      cfg_valid = 1'b1;
      cfg_bitwidth = 2'b11;
      tick();
      cfg_valid = 1'b0;
      @(negedge clk);
      chk("bw_illegal_keep", 32'(xbar_bitwidth), 0);
      chk("err_cfg", 32'(err_flags), 2);
      tick();
      cfg_valid = 1'b1;
      err_clear = 1'b1;
      tick();
      cfg_valid = 1'b0;
      err_clear = 1'b0;
      @(negedge clk);
      chk("err_new_beats_clear", 32'(err_flags), 2);
      tick();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      @(negedge clk);
      chk("err_cleared", 32'(err_flags), 0);

      // tiles: no stall, 5 stalls, last tile with drain
      tick();
      run_tile(1'b0, 0);
      chk("busy_after", 32'(busy), 0);
      tick();
      run_tile(1'b0, 5);
      tick();
      run_tile(1'b1, 0);
      chk("drain1_cfgrdy", 32'(cfg_ready), 0);
      chk("drain1_busy", 32'(busy), 1);
      chk("drain1_hold", 32'(operand_hold), 0);
      chk("drain_bw", 32'(xbar_bitwidth), 0);
      tick();
      @(negedge clk);
      chk("drain2_cfgrdy", 32'(cfg_ready), 0);
      tick();
      @(negedge clk);
      chk("post_drain_cfgrdy", 32'(cfg_ready), 1);
      chk("post_drain_busy", 32'(busy), 0);

      // stuck stall forces completion
      tick();
      run_tile(1'b0, 100);
      chk("err_timeout", 32'(err_flags), 1);
      tick();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      @(negedge clk);
      chk("err_timeout_clr", 32'(err_flags), 0);

      tick();
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      m_tiles  = 0;
      m_stalls = 0;
      @(negedge clk);
      chk("stat_clr_tiles", stat_tiles, 0);
      chk("stat_clr_stalls", stat_stall_cycles, 0);

      // cfg and tile together: cfg first, tile next cycle
      tick();
      cfg_valid = 1'b1;
      cfg_bitwidth = 2'b01;
      tile_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      run_tile(1'b0, 1);
      chk("bw_4b", 32'(xbar_bitwidth), 1);

      // reset in the middle of WAIT
      tick();
      tile_valid = 1'b1;
      tick();
      xbar_stall = 1'b1;
      tick();
      tick();
      reset_n    = 1'b0;
      tile_valid = 1'b0;
      xbar_stall = 1'b0;
      #1;
      chk_reset("midrst");
      m_tiles  = 0;
      m_stalls = 0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      run_tile(1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
